coin_acceptor: RTL

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces coin insertions, keeps credit and issues turnstile tokens.
// Tokens wait for an unlock acknowledge; an unacknowledged fare is returned to credit.
module coin_acceptor #(
  parameter int FARE        = 100,
  parameter int CREDIT_MAX  = 200,
  parameter int DEBOUNCE    = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_det,
  input  logic [1:0] coin_val,
  input  logic       refund,
  input  logic       unlocked,
  output logic       coin,
  output logic [7:0] credit,
  output logic       reject,
  output logic       refund_valid,
  output logic [7:0] refund_amt,
  output logic       fault
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t      state_reg, state_next;
  logic [DW-1:0] deb_reg, deb_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [7:0]  credit_reg, credit_next;
  logic        coin_reg, coin_next;
  logic        reject_reg, reject_next;
  logic        refund_valid_reg, refund_valid_next;
  logic [7:0]  refund_amt_reg, refund_amt_next;
  logic        fault_reg, fault_next;

  logic        coin_event;
  logic        accept;
  logic        issue;
  logic [9:0]  value;
  logic [9:0]  eff_credit;
  logic [9:0]  sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      deb_reg          <= '0;
      tmo_reg          <= '0;
      credit_reg       <= '0;
      coin_reg         <= 1'b0;
      reject_reg       <= 1'b0;
      refund_valid_reg <= 1'b0;
      refund_amt_reg   <= '0;
      fault_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      deb_reg          <= deb_next;
      tmo_reg          <= tmo_next;
      credit_reg       <= credit_next;
      coin_reg         <= coin_next;
      reject_reg       <= reject_next;
      refund_valid_reg <= refund_valid_next;
      refund_amt_reg   <= refund_amt_next;
      fault_reg        <= fault_next;
    end
  end

  always_comb begin
    // Saturating at DEBOUNCE guarantees a single event per high period.
    deb_next = deb_reg;
    if (!coin_det)
      deb_next = '0;
    else if (deb_reg != DW'(DEBOUNCE))
      deb_next = deb_reg + 1'b1;
    coin_event = coin_det && (deb_reg == DW'(DEBOUNCE - 1));

    case (coin_val)
      2'b01:   value = 10'd25;
      2'b10:   value = 10'd50;
      2'b11:   value = 10'd100;
      default: value = 10'd0;
    endcase

    // An outstanding token still counts against the credit ceiling, so a timeout refund cannot overflow.
    eff_credit = {2'b00, credit_reg} + ((state_reg == WAIT_ACK) ? 10'(FARE) : 10'd0);
    accept     = coin_event && (coin_val != 2'b00) && (eff_credit + value <= 10'(CREDIT_MAX));
    sum        = {2'b00, credit_reg} + (accept ? value : 10'd0);
    issue      = (state_reg == IDLE) && ({2'b00, credit_reg} >= 10'(FARE)) && !unlocked;

    state_next        = state_reg;
    tmo_next          = tmo_reg;
    credit_next       = sum[7:0];
    coin_next         = 1'b0;
    reject_next       = coin_event && !accept;
    refund_valid_next = 1'b0;
    refund_amt_next   = '0;
    fault_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        tmo_next = '0;
        if (issue) begin
          coin_next   = 1'b1;
          credit_next = 8'(sum - 10'(FARE));
          state_next  = WAIT_ACK;
        end else if (refund && (sum != 10'd0)) begin
          refund_valid_next = 1'b1;
          refund_amt_next   = sum[7:0];
          credit_next       = '0;
        end
      end
      WAIT_ACK: begin
        if (unlocked) begin
          state_next = IDLE;
          tmo_next   = '0;
        end else if (tmo_reg == TW'(ACK_TIMEOUT - 1)) begin
          fault_next  = 1'b1;
          credit_next = 8'(sum + 10'(FARE));
          state_next  = IDLE;
          tmo_next    = '0;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign coin         = coin_reg;
  assign credit       = credit_reg;
  assign reject       = reject_reg;
  assign refund_valid = refund_valid_reg;
  assign refund_amt   = refund_amt_reg;
  assign fault        = fault_reg;

endmodule
